// File: rtl/mem_stage.sv
// mem_stage: data-memory stage with word-organised sync RAM, LAT wait states and pipeline stall.
// Optional MEM_MISALIGN_TRAP_EN flags and suppresses misaligned half/word accesses.
module mem_stage #(
  parameter int RFW = 5,
  parameter int DW  = 32,
  parameter int IW  = 32,
  parameter int DMW = 8,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  inst,
  input  logic [RFW-1:0] rd,
  input  logic [DW-1:0]  alu_result,
  input  logic [DW-1:0]  store_data,
  output logic [DW-1:0]  data_out,
  output logic [IW-1:0]  inst_o,
  output logic [RFW-1:0] rd_o,
  output logic           stall,
  output logic           misalign
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] mem [0:(1<<DMW)-1];
  logic [6:0] opcode;
  logic [2:0] f3;
  logic is_load, is_store, is_mem, mis, we;
  logic [DMW-1:0] idx;
  logic [1:0] lane;
  logic [3:0] be;
  logic [DW-1:0] wd, ld;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign is_load  = opcode == 7'b0000011 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
  assign is_store = opcode == 7'b0100011 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
  assign is_mem   = is_load || is_store;
  assign idx      = alu_result[DMW+1:2];
  assign lane     = alu_result[1:0];
  assign inst_o   = inst;
  assign rd_o     = rd;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = is_mem && ((f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != 2'b00));
`else
  assign mis = 1'b0;
`endif
  assign be = f3[1:0] == 2'b00 ? 4'b0001 << lane :
              f3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = f3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
              f3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  assign we = state == DONE && is_store && !mis;
  assign byte_v = rdata_q[{lane, 3'b000} +: 8];
  assign half_v = lane[1] ? rdata_q[31:16] : rdata_q[15:0];
  always_comb begin
    ld = f3 == 3'b000 ? {{(DW-8){byte_v[7]}}, byte_v} :
         f3 == 3'b001 ? {{(DW-16){half_v[15]}}, half_v} :
         f3 == 3'b100 ? {{(DW-8){1'b0}}, byte_v} :
         f3 == 3'b101 ? {{(DW-16){1'b0}}, half_v} : rdata_q;
    data_out = state == DONE && is_load ? (mis ? '0 : ld) : alu_result;
    stall    = state == BUSY || (state == IDLE && is_mem);
    misalign = state == DONE && mis;
  end
  always_comb begin
    state_n = state == IDLE ? (is_mem ? (LAT == 1 ? DONE : BUSY) : IDLE) :
              state == BUSY ? (cnt == 4'd1 ? DONE : BUSY) : IDLE;
    cnt_n   = state == IDLE && is_mem ? 4'(LAT - 1) :
              state == BUSY ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state_n == DONE && state != DONE) rdata_q <= mem[idx];
    end
  end
  // RAM has no reset; a store aborted by rst at its commit edge is dropped
  always_ff @(posedge clk) begin
    if (!rst && we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage at LAT=2, plus stall width at LAT=1 and LAT=15.
module tb_mem_stage;
  localparam logic [31:0] NOP = 32'h00000013, ADD = 32'h00c58533;
  localparam logic [31:0] LB = 32'h00000003, LH = 32'h00001003, LW = 32'h00002003, LX = 32'h00003003;
  localparam logic [31:0] LBU = 32'h00004003, LHU = 32'h00005003;
  localparam logic [31:0] SB = 32'h00000023, SH = 32'h00001023, SW = 32'h00002023, SX = 32'h00003023;
  logic clk = 0, rst = 1;
  logic [31:0] inst = NOP, inst1 = NOP, inst15 = NOP, alu_result = 0, store_data = 0;
  logic [4:0] rd = 0;
  logic [31:0] data_out, data_out1, data_out15, inst_o, inst_o1, inst_o15;
  logic [4:0] rd_o, rd_o1, rd_o15;
  logic stall, stall1, stall15, misalign, misalign1, misalign15;
  int errs = 0, checks = 0, n;
  logic [31:0] q;
  logic m;
  always #5 clk = ~clk;
  mem_stage #(.LAT(2)) u2 (.clk(clk), .rst(rst), .inst(inst), .rd(rd), .alu_result(alu_result),
    .store_data(store_data), .data_out(data_out), .inst_o(inst_o), .rd_o(rd_o), .stall(stall), .misalign(misalign));
  mem_stage #(.LAT(1)) u1 (.clk(clk), .rst(rst), .inst(inst1), .rd(rd), .alu_result(alu_result),
    .store_data(store_data), .data_out(data_out1), .inst_o(inst_o1), .rd_o(rd_o1), .stall(stall1), .misalign(misalign1));
  mem_stage #(.LAT(15)) u15 (.clk(clk), .rst(rst), .inst(inst15), .rd(rd), .alu_result(alu_result),
    .store_data(store_data), .data_out(data_out15), .inst_o(inst_o15), .rd_o(rd_o15), .stall(stall15), .misalign(misalign15));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [31:0] i, input logic [31:0] a, input logic [31:0] d,
                    output int cyc, output logic [31:0] dout, output logic mflag);
    inst = i; alu_result = a; store_data = d; cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall) break;
      cyc++;
    end
    if (cyc >= 40) begin
      errs++;
      $error("FAIL op_wait_expired: stall still high after %0d cycles", cyc);
    end
    dout = data_out; mflag = misalign;
    @(posedge clk); #1 inst = NOP;
  endtask
  task automatic pulse(input int w, output int cyc);
    if (w == 1) inst1 = LW; else inst15 = LW;
    cyc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!(w == 1 ? stall1 : stall15)) break;
      cyc++;
    end
    if (cyc >= 60) begin
      errs++;
      $error("FAIL pulse_wait_expired: stall still high after %0d cycles", cyc);
    end
    @(posedge clk); #1 inst1 = NOP; inst15 = NOP;
  endtask
  initial begin
    alu_result = 32'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_passthru", data_out, 32'h55);
    @(posedge clk); #1 rst = 0;
    op(SW, 32'h10, 32'hDEADBEEF, n, q, m);
    chk("sw_stall", n, 2);
    chk("sw_dout", q, 32'h10);
    op(LW, 32'h10, 0, n, q, m);
    chk("lw_stall", n, 2);
    chk("lw_data", q, 32'hDEADBEEF);
    chk("lw_mis", m, 1'b0);
    op(SB, 32'h13, 32'h12345680, n, q, m);
    chk("sb_stall", n, 2);
    op(LB, 32'h13, 0, n, q, m);
    chk("lb_data", q, 32'hFFFFFF80);
    op(LBU, 32'h13, 0, n, q, m);
    chk("lbu_data", q, 32'h00000080);
    op(LW, 32'h10, 0, n, q, m);
    chk("lw_after_sb", q, 32'h80ADBEEF);
    op(LH, 32'h12, 0, n, q, m);
    chk("lh_hi", q, 32'hFFFF80AD);
    op(LHU, 32'h10, 0, n, q, m);
    chk("lhu_lo", q, 32'h0000BEEF);
    op(LB, 32'h11, 0, n, q, m);
    chk("lb_lane1", q, 32'hFFFFFFBE);
    op(LBU, 32'h10, 0, n, q, m);
    chk("lbu_lane0", q, 32'h000000EF);
    inst = ADD; rd = 5'd7; alu_result = 32'h1234; #1;
    chk("add_inst_o", inst_o, ADD);
    chk("add_rd_o", rd_o, 5'd7);
    op(ADD, 32'h1234, 0, n, q, m);
    chk("add_stall", n, 0);
    chk("add_dout", q, 32'h1234);
    op(LX, 32'h10, 0, n, q, m);
    chk("bad_load_stall", n, 0);
    chk("bad_load_dout", q, 32'h10);
    op(SX, 32'h10, 0, n, q, m);
    chk("bad_store_stall", n, 0);
    op(LW, 32'h10, 0, n, q, m);
    chk("bad_store_nowrite", q, 32'h80ADBEEF);
    op(SW, 32'h20, 32'h11111111, n, q, m);
    inst = SW; alu_result = 32'h20; store_data = 32'hCAFEF00D;
    @(posedge clk); #1 rst = 1; inst = NOP;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_busy_stall", stall, 1'b0);
    @(posedge clk); #1;
    op(LW, 32'h20, 0, n, q, m);
    chk("rst_discard", q, 32'h11111111);
    op(SH, 32'h21, 32'hAAAA5678, n, q, m);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("sh_mis_flag", m, 1'b1);
    op(LW, 32'h20, 0, n, q, m);
    chk("sh_mis_nowrite", q, 32'h11111111);
    op(LW, 32'h22, 0, n, q, m);
    chk("lw_mis_flag", m, 1'b1);
    chk("lw_mis_zero", q, 32'h0);
    op(SH, 32'h22, 32'h00009999, n, q, m);
    op(LW, 32'h20, 0, n, q, m);
    chk("sh_hi", q, 32'h99991111);
`else
    chk("sh_mis_flag", m, 1'b0);
    op(LW, 32'h20, 0, n, q, m);
    chk("sh_lo_write", q, 32'h11115678);
    op(LW, 32'h22, 0, n, q, m);
    chk("lw_mis_flag", m, 1'b0);
    chk("lw_unaligned", q, 32'h11115678);
    op(SH, 32'h22, 32'h00009999, n, q, m);
    op(LW, 32'h20, 0, n, q, m);
    chk("sh_hi", q, 32'h99995678);
`endif
    op(SW, 32'h410, 32'h0BADF00D, n, q, m);
    op(LW, 32'h10, 0, n, q, m);
    chk("addr_wrap", q, 32'h0BADF00D);
    pulse(1, n);
    chk("lat1_stall", n, 1);
    pulse(15, n);
    chk("lat15_stall", n, 15);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
